// File: rtl/traffic_light_2way_if.sv
// Lamp, countdown and stop-request bundle for the two-road light controller.
// The controller owns the lamps/digit/state code, the environment owns stop.
interface traffic_light_2way_if;
  logic       stop;
  logic       xa;
  logic       va;
  logic       da;
  logic       xb;
  logic       vb;
  logic       db;
  logic [7:0] HEX;
  logic [2:0] c;

  // Environment side: issues the hold request, observes the lamps
  modport master (
    output stop,
    input  xa, va, da, xb, vb, db, HEX, c
  );

  // Controller side
  modport slave (
    input  stop,
    output xa, va, da, xb, vb, db, HEX, c
  );
endinterface

// File: rtl/traffic_light_2way.sv
// Two-road intersection light controller. Phases cycle A green, A yellow,
// all-red clearance, B green, B yellow, all-red clearance. A stop request
// cuts the current green short and parks the intersection all-red in HOLD.
// Phase lengths are counted in ticks produced by a TICK_DIV prescaler; the
// remaining ticks of the current phase are shown on an active-low digit.
module traffic_light_2way #(
  parameter int unsigned GREEN_T  = 6,
  parameter int unsigned YELLOW_T = 2,
  parameter int unsigned CLEAR_T  = 1,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                 ck,
  input  logic                 rs,
  traffic_light_2way_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [3:0]    GREEN_R  = 4'(GREEN_T);
  localparam logic [3:0]    YELLOW_R = 4'(YELLOW_T);
  localparam logic [3:0]    CLEAR_R  = 4'(CLEAR_T);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    CLR_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    CLR_BA = 3'd5,
    HOLD   = 3'd6
  } state_e;

  // Lamp vector order is {xa, va, da, xb, vb, db}; all-red is the fallback.
  function automatic logic [5:0] lamps_of(input state_e s);
    case (s)
      A_GRN:   lamps_of = 6'b100_001;
      A_YEL:   lamps_of = 6'b010_001;
      B_GRN:   lamps_of = 6'b001_100;
      B_YEL:   lamps_of = 6'b001_010;
      default: lamps_of = 6'b001_001;
    endcase
  endfunction

  // Active-low digit {dp,g,f,e,d,c,b,a}; blank for anything outside 1..9.
  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    rem_q,   rem_d;
  logic [PW-1:0] pre_q,   pre_d;
  logic          last_q,  last_d;
  logic [5:0]    lamps_q, lamps_d;
  logic [7:0]    hex_q,   hex_d;

  logic tick;
  logic expire;

  assign tick   = (pre_q == PRE_LAST);
  assign expire = tick && (rem_q <= 4'd1);

  // Next phase, countdown and prescaler; outputs decoded from the next state
  // so the lamps and digit come straight out of flops.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    rem_d   = (tick && rem_q > 4'd1) ? rem_q - 4'd1 : rem_q;
    pre_d   = tick ? '0 : pre_q + PW'(1);
    last_d  = last_q;

    case (state_q)
      A_GRN: begin
        if (bus.stop || expire) begin
          state_d = A_YEL;
          rem_d   = YELLOW_R;
        end
      end
      A_YEL: begin
        if (expire) begin
          state_d = CLR_AB;
          rem_d   = CLEAR_R;
          last_d  = 1'b0;
        end
      end
      CLR_AB: begin
        if (expire) begin
          state_d = bus.stop ? HOLD : B_GRN;
          rem_d   = bus.stop ? 4'd0 : GREEN_R;
        end
      end
      B_GRN: begin
        if (bus.stop || expire) begin
          state_d = B_YEL;
          rem_d   = YELLOW_R;
        end
      end
      B_YEL: begin
        if (expire) begin
          state_d = CLR_BA;
          rem_d   = CLEAR_R;
          last_d  = 1'b1;
        end
      end
      CLR_BA: begin
        if (expire) begin
          state_d = bus.stop ? HOLD : A_GRN;
          rem_d   = bus.stop ? 4'd0 : GREEN_R;
        end
      end
      HOLD: begin
        // Resume with the road that did not have the last green.
        rem_d = 4'd0;
        pre_d = '0;
        if (!bus.stop) begin
          state_d = last_q ? A_GRN : B_GRN;
          rem_d   = GREEN_R;
        end
      end
      default: begin
        state_d = A_GRN;
        rem_d   = GREEN_R;
      end
    endcase

    // Every phase starts with a fresh prescaler so it lasts duration*TICK_DIV.
    if (state_d != state_q) pre_d = '0;

    lamps_d = lamps_of(state_d);
    hex_d   = (state_d == HOLD) ? 8'hBF : seg7(rem_d);
  end

  // State, counters and registered outputs; synchronous reset wins over stop.
  always_ff @(posedge ck) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, so ordering inside the block does not matter.
    if (rs) begin
      state_q <= A_GRN;
      rem_q   <= GREEN_R;
      pre_q   <= '0;
      last_q  <= 1'b0;
      lamps_q <= lamps_of(A_GRN);
      hex_q   <= seg7(GREEN_R);
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
      last_q  <= last_d;
      lamps_q <= lamps_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.c = state_q;
  assign {bus.xa, bus.va, bus.da, bus.xb, bus.vb, bus.db} = lamps_q;
  assign bus.HEX = hex_q;

endmodule

// File: tb/tb_traffic_light_2way.sv
// Bench for traffic_light_2way: two instances (defaults, and TICK_DIV=4 with
// GREEN_T=3) are compared every cycle against a cycle-counting phase model,
// with directed scenarios pinned by literal expectations.
module tb_traffic_light_2way;

  logic ck;
  logic rs;

  int checks   = 0;
  int failures = 0;

  traffic_light_2way_if if0 ();
  traffic_light_2way_if if1 ();

  traffic_light_2way dut0 (
    .ck  (ck),
    .rs  (rs),
    .bus (if0.slave)
  );

  traffic_light_2way #(
    .GREEN_T  (3),
    .YELLOW_T (2),
    .CLEAR_T  (1),
    .TICK_DIV (4)
  ) dut1 (
    .ck  (ck),
    .rs  (rs),
    .bus (if1.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the phase and the number of clock cycles left in it; the shown
  // digit is the remaining cycles rounded up to whole ticks.
  function automatic int td_of(input int k);    return (k == 0) ? 1 : 4; endfunction
  function automatic int green_of(input int k); return (k == 0) ? 6 : 3; endfunction
  localparam int YEL = 2;
  localparam int CLR = 1;

  function automatic logic [7:0] seg_of(input int v);
    case (v)
      1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82;
      7: return 8'hF8; 8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // {xa,va,da,xb,vb,db}
  function automatic logic [5:0] lamps_exp(input int c);
    case (c)
      0: return 6'b100001;
      1: return 6'b010001;
      3: return 6'b001100;
      4: return 6'b001010;
      default: return 6'b001001;
    endcase
  endfunction

  int m_c    [2];
  int m_left [2];
  int m_last [2];
  bit m_valid = 1'b0;

  task automatic model_next(input int k, input logic r, input logic s,
                            output int nc, output int nl, output int nlast);
    int td, g;
    td = td_of(k);
    g  = green_of(k);
    nc = m_c[k]; nl = m_left[k]; nlast = m_last[k];
    if (r) begin
      nc = 0; nl = g * td; nlast = 0;
    end else if (m_c[k] == 6) begin
      if (!s) begin
        nc = (m_last[k] != 0) ? 0 : 3;
        nl = g * td;
      end
    end else if (s && (m_c[k] == 0 || m_c[k] == 3)) begin
      nc = m_c[k] + 1;
      nl = YEL * td;
    end else begin
      nl = m_left[k] - 1;
      if (nl == 0) begin
        case (m_c[k])
          0: begin nc = 1; nl = YEL * td; end
          1: begin nc = 2; nl = CLR * td; nlast = 0; end
          2: begin nc = s ? 6 : 3; nl = s ? 0 : g * td; end
          3: begin nc = 4; nl = YEL * td; end
          4: begin nc = 5; nl = CLR * td; nlast = 1; end
          default: begin nc = s ? 6 : 0; nl = s ? 0 : g * td; end
        endcase
      end
    end
  endtask

  always @(posedge ck) begin
    int nc, nl, nla;
    logic [1:0] st;
    st = {if1.stop, if0.stop};
    for (int k = 0; k < 2; k++) begin
      model_next(k, rs, st[k], nc, nl, nla);
      m_c[k]    <= nc;
      m_left[k] <= nl;
      m_last[k] <= nla;
    end
    if (rs) m_valid <= 1'b1;
  end

  // ---------------- per-cycle comparison ----------------
  task automatic compare(input int k, input logic [2:0] c, input logic [5:0] lamps,
                         input logic [7:0] hex);
    int td;
    logic [7:0] hex_e;
    td    = td_of(k);
    hex_e = (m_c[k] == 6) ? 8'hBF : seg_of((m_left[k] + td - 1) / td);
    check($sformatf("model_c[%0d]", k), {29'd0, c}, m_c[k]);
    check($sformatf("model_lamps[%0d]", k), {26'd0, lamps}, {26'd0, lamps_exp(m_c[k])});
    check($sformatf("model_hex[%0d]", k), {24'd0, hex}, {24'd0, hex_e});
    check($sformatf("no_both_green[%0d]", k), {31'd0, lamps[5] & lamps[2]}, 32'd0);
    check($sformatf("one_lamp_a[%0d]", k), $countones(lamps[5:3]), 32'd1);
    check($sformatf("one_lamp_b[%0d]", k), $countones(lamps[2:0]), 32'd1);
    check($sformatf("c_legal[%0d]", k), {31'd0, c == 3'd7}, 32'd0);
  endtask

  always @(negedge ck) begin
    if (m_valid) begin
      compare(0, if0.c, {if0.xa, if0.va, if0.da, if0.xb, if0.vb, if0.db}, if0.HEX);
      compare(1, if1.c, {if1.xa, if1.va, if1.da, if1.xb, if1.vb, if1.db}, if1.HEX);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge ck);
  endtask

  task automatic expect0(input string name, input logic [2:0] c, input logic [7:0] hex);
    check({name, "_c"}, {29'd0, if0.c}, {29'd0, c});
    check({name, "_hex"}, {24'd0, if0.HEX}, {24'd0, hex});
  endtask

  task automatic expect1(input string name, input logic [2:0] c, input logic [7:0] hex);
    check({name, "_c"}, {29'd0, if1.c}, {29'd0, c});
    check({name, "_hex"}, {24'd0, if1.HEX}, {24'd0, hex});
  endtask

  task automatic wait_c0(input logic [2:0] tgt, input int budget);
    int n;
    n = 0;
    while (if0.c !== tgt && n < budget) begin
      step();
      n++;
    end
    check("wait_state", {29'd0, if0.c}, {29'd0, tgt});
  endtask

  logic [7:0] loop_hex [10] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9,
                                8'hA4, 8'hF9, 8'hF9, 8'h82};
  logic [2:0] loop_c   [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                3'd1, 3'd1, 3'd2, 3'd3};

  initial begin
    rs       = 1'b1;
    if0.stop = 1'b0;
    if1.stop = 1'b0;
    repeat (2) step();
    rs = 1'b0;

    // Free-running loop with defaults; first A_GRN cycle is i=0.
    check("reset_lamps", {26'd0, if0.xa, if0.va, if0.da, if0.xb, if0.vb, if0.db},
          32'b100001);
    for (int i = 0; i <= 18; i++) begin
      if (i > 0) step();
      if (i < 10) expect0($sformatf("loop%0d", i), loop_c[i], loop_hex[i]);
      if (i == 18) expect0("loop_wrap", 3'd0, 8'h82);
    end

    // Stop raised in the 3rd A_GRN cycle.
    repeat (2) step();
    if0.stop = 1'b1;
    step(); expect0("stopA_yel1", 3'd1, 8'hA4);
    check("stopA_va", {31'd0, if0.va}, 32'd1);
    step(); expect0("stopA_yel2", 3'd1, 8'hF9);
    step(); expect0("stopA_clr", 3'd2, 8'hF9);
    step(); expect0("stopA_hold", 3'd6, 8'hBF);
    check("hold_red", {30'd0, if0.da, if0.db}, 32'b11);
    repeat (3) begin step(); expect0("hold_stay", 3'd6, 8'hBF); end

    // Release: A side was last green, so B goes next.
    if0.stop = 1'b0;
    step(); expect0("holdA_exit", 3'd3, 8'h82);
    check("holdA_exit_lamps", {30'd0, if0.xb, if0.da}, 32'b11);

    // Terminate B green, hold, release to A.
    step();
    if0.stop = 1'b1;
    step(); expect0("stopB_yel1", 3'd4, 8'hA4);
    step(); expect0("stopB_yel2", 3'd4, 8'hF9);
    step(); expect0("stopB_clr", 3'd5, 8'hF9);
    step(); expect0("stopB_hold", 3'd6, 8'hBF);
    step();
    if0.stop = 1'b0;
    step(); expect0("holdB_exit", 3'd0, 8'h82);

    // Reset during B_YEL.
    wait_c0(3'd3, 40);
    if0.stop = 1'b1;
    step(); expect0("pre_rst_byel", 3'd4, 8'hA4);
    rs = 1'b1;
    step(); expect0("rst_byel", 3'd0, 8'h82);
    check("rst_byel_lamps", {26'd0, if0.xa, if0.va, if0.da, if0.xb, if0.vb, if0.db},
          32'b100001);
    rs = 1'b0;

    // Reset during HOLD with stop still asserted.
    wait_c0(3'd6, 40);
    rs = 1'b1;
    step(); expect0("rst_hold", 3'd0, 8'h82);
    rs = 1'b0;
    if0.stop = 1'b0;

    // TICK_DIV=4, GREEN_T=3 instance: 12-cycle green, digit steps every 4.
    rs = 1'b1;
    step();
    rs = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) step();
      if (i < 12)
        expect1($sformatf("div_grn%0d", i), 3'd0, (i < 4) ? 8'hB0 : (i < 8) ? 8'hA4 : 8'hF9);
      else
        expect1("div_yel", 3'd1, 8'hA4);
    end

    // Stop mid-tick: yellow must still last the full 8 cycles.
    rs = 1'b1;
    step();
    rs = 1'b0;
    repeat (2) step();
    if1.stop = 1'b1;
    step(); expect1("div_stop_yel", 3'd1, 8'hA4);
    if1.stop = 1'b0;
    repeat (7) step();
    expect1("div_yel_last", 3'd1, 8'hF9);
    step(); expect1("div_clr", 3'd2, 8'hF9);

    // Random stop traffic on both instances; the model checks every cycle.
    repeat (200) begin
      step();
      if0.stop = ($urandom_range(0, 3) == 0);
      if1.stop = ($urandom_range(0, 3) == 0);
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
